otg_hpi_master: RTL and testbench
=================================

# otg_hpi_master

Hardware HPI bus initiator for the CY7C67200 USB OTG controller. It replaces the bit-banged PIO ports with one Avalon-MM slave. Each Avalon read or write becomes one timed HPI cycle on the chip pins, with stalls driven by `avs_waitrequest`. It sits between the Nios II data bus and the top-level OTG pin tri-state buffers.

## Interface
Parameters:
- SETUP_CYC, 2, clocks from `otg_cs_n` low (address/data valid) to strobe low; legal range 1..255
- STROBE_CYC, 6, clocks `otg_rd_n`/`otg_wr_n` held low; legal range 1..255
- HOLD_CYC, 2, clocks from strobe high to `otg_cs_n` high; legal range 1..255
- RECOVERY_CYC, 4, idle clocks forced between HPI cycles; legal range 0..255

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  2  HPI register: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- avs_chipselect  in  1  slave select
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data; bits [15:0] are used
- avs_readdata  out  32  {16'b0, last captured HPI word}
- avs_waitrequest  out  1  stall for the active request
- otg_addr  out  2  HPI address pins
- otg_cs_n  out  1  HPI chip select, active low
- otg_rd_n  out  1  HPI read strobe, active low
- otg_wr_n  out  1  HPI write strobe, active low
- otg_data_out  out  16  data driven to pins
- otg_data_oe  out  1  tri-state enable for `otg_data_out`
- otg_data_in  in  16  data sampled from pins
- otg_int  in  1  HPI_INT from chip, active high
- irq  out  1  level interrupt to Nios II

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One 8-bit down-counter is loaded on each state entry.
- Request = `avs_chipselect & (avs_read | avs_write)`. If `avs_chipselect` is low, the request is ignored.
- If read and write are asserted together, the write wins.
- IDLE with a request: latch address, direction and writedata[15:0], then go to SETUP.
- SETUP: `otg_cs_n`=0, `otg_addr` valid. For writes, `otg_data_oe`=1 with data valid. Lasts SETUP_CYC clocks, then go to STROBE.
- STROBE: the `otg_rd_n` or `otg_wr_n` strobe is low for STROBE_CYC clocks.
  - Reads capture `otg_data_in` on the clock edge that ends the last STROBE clock.
  - Then go to HOLD.
- HOLD: strobe high; cs_n, addr and oe stay unchanged for HOLD_CYC clocks.
  - `avs_waitrequest` is low during the last HOLD clock (the ack cycle).
  - Then go to RECOVER, or straight to IDLE if RECOVERY_CYC=0.
- RECOVER: all strobes and cs_n high, oe=0. Lasts RECOVERY_CYC clocks, then go to IDLE.
- `avs_waitrequest` = request & ~ack. It is combinational and stays high for requests arriving outside IDLE, until their own ack.
- `avs_readdata` is driven from the capture register. It holds its value across writes and idle periods.
- All `otg_*` outputs are registered and glitch-free. `otg_addr` and `otg_data_out` keep their last values after the cycle.

## Timing
- Reset (async): state IDLE, counter 0, `otg_cs_n`/`otg_rd_n`/`otg_wr_n`=1, `otg_data_oe`=0, `otg_addr`=0, `otg_data_out`=0, capture register 0 (so `avs_readdata`=0), `irq`=0.
- `avs_waitrequest` = request & ~ack from reset onward; it is not forced to a fixed reset value.
- Reset mid-cycle: strobes and cs_n go high immediately and the transaction is dropped. No ack is given.
- Clock numbering: request sampled in IDLE is clock 0.
  - SETUP: clocks 1..S.
  - STROBE: clocks S+1..S+T.
  - HOLD: clocks S+T+1..S+T+H.
  - Ack: clock S+T+H.
  - Next request accepted in IDLE at clock S+T+H+R+1.
- With defaults: ack at clock 10, next acceptance at clock 15, so back-to-back throughput is one HPI cycle per 15 clocks.

## Configuration
- `OTG_HPI_MASTER_IRQ_EN` defined:
  - `otg_int` passes through a 2-flop synchronizer and `irq` = synchronized value.
  - Interrupt assertion latency is 2 clocks.
  - Both flops reset to 0.
- Not defined: `otg_int` is unused and `irq` is tied to 0.
- Both ports exist in either build.

## Test plan
- Write addr 2, data 0x1234, defaults -> `otg_cs_n` low clocks 1-10, `otg_wr_n` low clocks 3-8, `otg_addr`=2, `otg_data_oe`=1 clocks 1-10, `otg_data_out`=0x1234, waitrequest low only in clock 10.
- Read addr 0, pins driven 0xBEEF during STROBE -> `otg_rd_n` low clocks 3-8, `otg_data_oe`=0 throughout, `avs_readdata`=0x0000BEEF at ack in clock 10.
- Back-to-back write then read held asserted -> second cycle's `otg_cs_n` falls at clock 16, exactly 5 clocks after the first cycle's `otg_cs_n` rises.
- Read and write asserted together, addr 1, data 0x00AA -> only `otg_wr_n` pulses, `otg_rd_n` stays 1.
- Assert reset_n low at clock 5 during a write -> `otg_wr_n`/`otg_cs_n` go high asynchronously, `otg_data_oe`=0. After release, a new request starts cleanly at SETUP.
- With `OTG_HPI_MASTER_IRQ_EN`: pulse `otg_int` high for 4 clocks -> `irq` high for 4 clocks, starting 2 clocks later. Without the macro: `irq` stays 0.

Source files
------------

// File: rtl/otg_hpi_master.sv
// otg_hpi_master
// ----------------------------------------------------------------------------
// Hardware HPI bus initiator for the CY7C67200 USB OTG controller. Each
// Avalon-MM read or write becomes one timed HPI cycle on the chip pins:
// SETUP (cs_n low, address/data valid), STROBE (rd_n or wr_n low), HOLD
// (strobe released, cs_n/addr/oe kept), then an optional RECOVER gap.
// The Avalon side is stalled with avs_waitrequest until the last HOLD clock.
//
// Optional feature macro: OTG_HPI_MASTER_IRQ_EN
//   defined   : otg_int is double-flopped onto irq (2 clock latency)
//   undefined : otg_int is ignored and irq is tied low
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   avs_address         HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   avs_chipselect      slave select; requests without it are ignored
//   avs_read/avs_write  request strobes (write wins if both are set)
//   avs_writedata       write data, bits [15:0] used
//   avs_readdata        {16'b0, last word captured from the pins}
//   avs_waitrequest     stall for the active request
//   otg_addr            HPI address pins
//   otg_cs_n/rd_n/wr_n  HPI chip select and strobes, active low
//   otg_data_out/_oe    data to the pin tri-state buffer and its enable
//   otg_data_in         data sampled from the pins
//   otg_int             HPI_INT from the chip
//   irq                 level interrupt to the Nios II
// ----------------------------------------------------------------------------
module otg_hpi_master #(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 6,
    parameter int HOLD_CYC     = 2,
    parameter int RECOVERY_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    input  logic        otg_int,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    // The counter is loaded with (length - 1) on entry, so a phase of N
    // clocks ends in the clock where the counter reads zero.
    localparam logic [7:0] SETUP_LOAD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LOAD  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LOAD = (RECOVERY_CYC > 0) ? 8'(RECOVERY_CYC - 1) : 8'd0;

    state_t      state;
    state_t      next_state;
    logic [7:0]  count;
    logic [7:0]  next_count;
    logic        is_write;
    logic        next_is_write;
    logic        next_busy;
    logic [15:0] capture;
    logic        request;
    logic        count_done;
    logic        ack;
    logic        accept;
    logic        unused_bits;

    assign request    = avs_chipselect & (avs_read | avs_write);
    assign count_done = (count == 8'd0);
    assign ack        = (state == HOLD) && count_done;
    assign accept     = (state == IDLE) && request;

    // Combinational stall: any request, including one that arrives while a
    // previous HPI cycle is still running, waits until its own ack clock.
    assign avs_waitrequest = request & ~ack;
    assign avs_readdata    = {16'b0, capture};

    // The upper half of the write bus has no meaning on a 16-bit HPI port.
    assign unused_bits = ^avs_writedata[31:16];

    // State register together with the phase counter and latched direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= 8'd0;
            is_write <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            is_write <= next_is_write;
        end
    end

    // Next-state logic: every phase transition reloads the counter for the
    // phase being entered.
    always_comb begin
        next_state    = state;
        next_count    = count_done ? 8'd0 : count - 8'd1;
        next_is_write = is_write;
        case (state)
            IDLE: begin
                if (request) begin
                    next_state    = SETUP;
                    next_count    = SETUP_LOAD;
                    next_is_write = avs_write;
                end
            end
            SETUP: begin
                if (count_done) begin
                    next_state = STROBE;
                    next_count = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (count_done) begin
                    next_state = HOLD;
                    next_count = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (count_done) begin
                    if (RECOVERY_CYC > 0) begin
                        next_state = RECOVER;
                        next_count = RECOVER_LOAD;
                    end else begin
                        next_state = IDLE;
                        next_count = 8'd0;
                    end
                end
            end
            RECOVER: begin
                if (count_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_count = 8'd0;
            end
        endcase
    end

    assign next_busy = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);

    // Pin registers are driven from the next state so each pin changes on the
    // same edge the FSM enters the matching phase, with no decode glitches.
    // Address and write data are captured at acceptance and then left alone
    // so the pins keep their last values between cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            otg_addr     <= 2'd0;
            otg_data_out <= 16'd0;
            capture      <= 16'd0;
        end else begin
            otg_cs_n    <= ~next_busy;
            otg_rd_n    <= ~((next_state == STROBE) && !next_is_write);
            otg_wr_n    <= ~((next_state == STROBE) && next_is_write);
            otg_data_oe <= next_busy && next_is_write;
            if (accept) begin
                otg_addr <= avs_address;
                if (avs_write) begin
                    otg_data_out <= avs_writedata[15:0];
                end
            end
            if ((state == STROBE) && count_done && !is_write) begin
                capture <= otg_data_in;
            end
        end
    end

`ifdef OTG_HPI_MASTER_IRQ_EN
    logic int_meta;
    logic int_sync;

    // Two-flop synchronizer: HPI_INT is asynchronous to the system clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= otg_int;
            int_sync <= int_meta;
        end
    end

    assign irq = int_sync;
`else
    logic unused_int;

    assign unused_int = otg_int;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_otg_hpi_master.sv
// tb_otg_hpi_master
// ----------------------------------------------------------------------------
// Scoreboard bench for otg_hpi_master with default timing (S=2, T=6, H=2,
// R=4). Stimulus pushes the expected view of each HPI cycle into a queue; a
// negedge monitor profiles the pins (clock index from cs_n falling) and, at
// every Avalon ack, pops one entry and compares. Reset and interrupt
// behaviour are checked directly from the stimulus process.
// ----------------------------------------------------------------------------
module tb_otg_hpi_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  otg_addr;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_int;
    logic        irq;
    logic [15:0] chip_word;

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] dout;
        logic [15:0] rdata;
        logic        is_write;
        int          ack_idx;
        int          s_first;
        int          s_last;
        int          oe_cnt;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    otg_hpi_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .otg_addr        (otg_addr),
        .otg_cs_n        (otg_cs_n),
        .otg_rd_n        (otg_rd_n),
        .otg_wr_n        (otg_wr_n),
        .otg_data_out    (otg_data_out),
        .otg_data_oe     (otg_data_oe),
        .otg_data_in     (otg_data_in),
        .otg_int         (otg_int),
        .irq             (irq)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Chip model: it only drives a meaningful word while it is being read.
    assign otg_data_in = !otg_rd_n ? chip_word : 16'hDEAD;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [1:0] addr, input logic [15:0] dout, input logic [15:0] rdata,
                                input logic is_write, input int gap);
        exp_t e;
        e.addr     = addr;
        e.dout     = dout;
        e.rdata    = rdata;
        e.is_write = is_write;
        e.ack_idx  = 10;
        e.s_first  = 3;
        e.s_last   = 8;
        e.oe_cnt   = is_write ? 10 : 0;
        e.gap      = gap;
        sb.push_back(e);
    endtask

    // Avalon master: hold the request until waitrequest is seen low, let that
    // edge complete the transfer, then drop it.
    task automatic applyStimulus(input logic [1:0] addr, input logic rd, input logic wr, input logic [15:0] data);
        bit done = 1'b0;
        @(negedge clk);
        avs_address    = addr;
        avs_read       = rd;
        avs_write      = wr;
        avs_writedata  = {16'hFFFF, data};
        avs_chipselect = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no ack, want ack within 100 clocks");
        end
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
    endtask

    // Pin monitor and scoreboard consumer.
    int          idx = 0;
    int          wr_first, wr_last, rd_first, rd_last, oe_cnt;
    int          rise_cyc = -1000;
    int          last_gap = 0;
    logic        prev_cs = 1'b1;
    logic [1:0]  s_addr;
    logic [15:0] s_dout;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_cs = 1'b1;
            idx     = 0;
        end else begin
            if (!otg_cs_n) begin
                if (prev_cs) begin
                    idx      = 1;
                    wr_first = 0;
                    wr_last  = 0;
                    rd_first = 0;
                    rd_last  = 0;
                    oe_cnt   = 0;
                    last_gap = cyc - rise_cyc;
                end else begin
                    idx++;
                end
                if (!otg_wr_n) begin
                    if (wr_first == 0) wr_first = idx;
                    wr_last = idx;
                    s_addr  = otg_addr;
                    s_dout  = otg_data_out;
                end
                if (!otg_rd_n) begin
                    if (rd_first == 0) rd_first = idx;
                    rd_last = idx;
                    s_addr  = otg_addr;
                    s_dout  = otg_data_out;
                end
                if (otg_data_oe) oe_cnt++;
            end else if (!prev_cs) begin
                rise_cyc = cyc;
            end
            prev_cs = otg_cs_n;

            if (avs_chipselect && (avs_read || avs_write) && !avs_waitrequest) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: got ack at clock %0d, want none", idx);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_clock", idx, e.ack_idx);
                    if (e.is_write) begin
                        checkOutput("wr_first", wr_first, e.s_first);
                        checkOutput("wr_last", wr_last, e.s_last);
                        checkOutput("rd_unused", rd_first, 0);
                    end else begin
                        checkOutput("rd_first", rd_first, e.s_first);
                        checkOutput("rd_last", rd_last, e.s_last);
                        checkOutput("wr_unused", wr_first, 0);
                    end
                    checkOutput("oe_clocks", oe_cnt, e.oe_cnt);
                    checkOutput("strobe_addr", {30'd0, s_addr}, {30'd0, e.addr});
                    checkOutput("strobe_dout", {16'd0, s_dout}, {16'd0, e.dout});
                    checkOutput("readdata", avs_readdata, {16'd0, e.rdata});
                    if (e.gap >= 0) checkOutput("cs_gap", last_gap, e.gap);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int irq_first;
        int irq_cnt;

        reset_n        = 1'b0;
        avs_address    = 2'd0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = 32'd0;
        otg_int        = 1'b0;
        chip_word      = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_cs_n", otg_cs_n, 1);
        checkOutput("rst_rd_n", otg_rd_n, 1);
        checkOutput("rst_wr_n", otg_wr_n, 1);
        checkOutput("rst_oe", otg_data_oe, 0);
        checkOutput("rst_addr", otg_addr, 0);
        checkOutput("rst_dout", otg_data_out, 0);
        checkOutput("rst_readdata", avs_readdata, 0);
        checkOutput("rst_waitreq", avs_waitrequest, 0);
        checkOutput("rst_irq", irq, 0);

        $display("[TB] write addr 2, read addr 0");
        pushExpected(2'd2, 16'h1234, 16'h0000, 1'b1, -1);
        applyStimulus(2'd2, 1'b0, 1'b1, 16'h1234);
        repeat (8) @(negedge clk);
        chip_word = 16'hBEEF;
        pushExpected(2'd0, 16'h1234, 16'hBEEF, 1'b0, -1);
        applyStimulus(2'd0, 1'b1, 1'b0, 16'h0000);
        repeat (8) @(negedge clk);

        $display("[TB] back-to-back write then read");
        chip_word = 16'hCAFE;
        pushExpected(2'd3, 16'h5678, 16'hBEEF, 1'b1, -1);
        applyStimulus(2'd3, 1'b0, 1'b1, 16'h5678);
        pushExpected(2'd1, 16'h5678, 16'hCAFE, 1'b0, 5);
        applyStimulus(2'd1, 1'b1, 1'b0, 16'h0000);
        repeat (8) @(negedge clk);

        $display("[TB] read and write together");
        pushExpected(2'd1, 16'h00AA, 16'hCAFE, 1'b1, -1);
        applyStimulus(2'd1, 1'b1, 1'b1, 16'h00AA);
        repeat (8) @(negedge clk);

        $display("[TB] reset during a write");
        @(negedge clk);
        avs_address    = 2'd2;
        avs_write      = 1'b1;
        avs_writedata  = 32'h0000_9999;
        avs_chipselect = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        checkOutput("pre_rst_wr_n", otg_wr_n, 0);
        checkOutput("pre_rst_cs_n", otg_cs_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_wr_n", otg_wr_n, 1);
        checkOutput("mid_rst_cs_n", otg_cs_n, 1);
        checkOutput("mid_rst_oe", otg_data_oe, 0);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_readdata", avs_readdata, 0);
        checkOutput("post_rst_addr", otg_addr, 0);

        pushExpected(2'd0, 16'h0F0F, 16'h0000, 1'b1, -1);
        applyStimulus(2'd0, 1'b0, 1'b1, 16'h0F0F);
        repeat (8) @(negedge clk);
        chip_word = 16'h1357;
        pushExpected(2'd2, 16'h0F0F, 16'h1357, 1'b0, -1);
        applyStimulus(2'd2, 1'b1, 1'b0, 16'h0000);
        repeat (8) @(negedge clk);

        $display("[TB] interrupt pulse");
        @(posedge clk);
        #1;
        otg_int   = 1'b1;
        irq_first = -1;
        irq_cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq) begin
                if (irq_first < 0) irq_first = i;
                irq_cnt++;
            end
            @(posedge clk);
            #1;
            if (i == 3) otg_int = 1'b0;
        end
`ifdef OTG_HPI_MASTER_IRQ_EN
        checkOutput("irq_start", irq_first, 2);
        checkOutput("irq_clocks", irq_cnt, 4);
`else
        checkOutput("irq_start", irq_first, -1);
        checkOutput("irq_clocks", irq_cnt, 0);
`endif

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
